// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS main controller.
// Used by mc_ctrl (optional MC_PERF_CNT_EN counters) and mc_ctrl_decode.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state -> datapath control word.
// Moore outputs, except FETCH ir_write/pc_write gated by mem_ready.
module mc_ctrl_decode (
    input  logic       mem_ready_i,
    input  logic [3:0] state_i,
    output logic       mem_req_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       halt_o
);
    import mc_pkg::*;

    state_e st;
    assign st = state_e'(state_i);

    // Control word for the current state; everything unlisted stays 0.
    always_comb begin
        mem_req_o       = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        iord_o          = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = PC_ALU;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = ALU_ADD;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        halt_o          = 1'b0;
        unique case (st)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: alu_src_b_o = SRCB_SHIMM;
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req_o  = 1'b1;
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEMWR: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_SUB;
                pc_write_cond_o = 1'b1;
                pc_src_o        = PC_ALUOUT;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_JUMP;
            end
            S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_ADDIWB: reg_write_o = 1'b1;
            S_TRAP:   halt_o      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller with memory wait and timeout.
// Define MC_PERF_CNT_EN to add the cyc_cnt/instr_cnt activity counters.
module mc_ctrl #(
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_read,
    output logic            mem_write,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic [1:0]      pc_src,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            halt,
    output logic [3:0]      state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]     cyc_cnt,
    output logic [31:0]     instr_cnt
`endif
);
    import mc_pkg::*;

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;

    // The datapath applies zero itself through pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    assign state_o = state_q;

    // State and memory wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, plus wait counting while a memory access stalls.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
        if (TIMEOUT > 0 && is_mem_state(state_q) && !mem_ready) begin
            if (wait_q == WW'(TIMEOUT - 1)) begin
                state_d = S_TRAP;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    mc_ctrl_decode u_decode (
        .mem_ready_i     (mem_ready),
        .state_i         (state_q),
        .mem_req_o       (mem_req),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .iord_o          (iord),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .pc_src_o        (pc_src),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .reg_write_o     (reg_write),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .halt_o          (halt)
    );

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q, instr_q;

    // Busy cycles outside IDLE/TRAP and completed instruction fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (state_q == S_FETCH && mem_ready) begin
                instr_q <= instr_q + 32'd1;
            end
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed plus random checks of mc_ctrl against a
// per-instruction phase-path model of the controller.
module tb_mc_ctrl;

    localparam int TMO = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst_n, start, zero, mem_ready;
    logic [5:0] op;
    logic       mem_req, mem_read, mem_write, iord, ir_write;
    logic       pc_write, pc_write_cond, alu_src_a;
    logic       reg_write, reg_dst, mem_to_reg, halt;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif

    mc_ctrl #(.OP_W(6), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .halt          (halt),
        .state_o       (state_o)
`ifdef MC_PERF_CNT_EN
        ,
        .cyc_cnt       (cyc_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        chk_en = 1'b0;
    int          ms = 0;
    int          pos = 0;
    int          wcnt = 0;
    logic        new_instr = 1'b0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  next_op = '0;
    logic [31:0] mcyc = '0;
    logic [31:0] minstr = '0;
    logic [5:0]  ops [6] = '{LW, SW, RT, BEQ, JMP, ADDI};

    logic [17:0] got_w;
    assign got_w = {mem_req, mem_read, mem_write, iord, ir_write,
                    pc_write, pc_write_cond, pc_src, alu_src_a,
                    alu_src_b, alu_op, reg_write, reg_dst,
                    mem_to_reg, halt};

    // Phase path of one instruction, one hex digit per cycle, 0 ends it.
    function automatic int step_of(input logic [5:0] o, input int i);
        logic [23:0] p;
        case (o)
            LW:      p = 24'h123450;
            SW:      p = 24'h123600;
            RT:      p = 24'h127800;
            BEQ:     p = 24'h129000;
            JMP:     p = 24'h12A000;
            ADDI:    p = 24'h12BC00;
            default: p = 24'h12F000;
        endcase
        return int'(p[23-4*i -: 4]);
    endfunction

    // Expected control word from the per-state output table.
    function automatic logic [17:0] exp_word(input int s, input logic rdy);
        logic rq, rd, wr, io, ir, pw, pwc, sa, rw, rdst, m2r, h;
        logic [1:0] ps, sb, ao;
        {rq, rd, wr, io, ir, pw, pwc, sa, rw, rdst, m2r, h} = '0;
        ps = 2'b00; sb = 2'b00; ao = 2'b00;
        case (s)
            1:  begin rq = 1; rd = 1; sb = 2'b01; ir = rdy; pw = rdy; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin rq = 1; rd = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin rq = 1; wr = 1; io = 1; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: rw = 1;
            15: h = 1;
            default: ;
        endcase
        return {rq, rd, wr, io, ir, pw, pwc, ps, sa, sb, ao, rw, rdst, m2r, h};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; pos = 0; wcnt = 0; mcyc = '0; minstr = '0;
    endtask

    // Advance the model by one clock using the inputs of the ending cycle.
    task automatic model_step();
        int nx;
        new_instr = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (ms != 0 && ms != 15) mcyc = mcyc + 32'd1;
        if (ms == 1 && mem_ready) minstr = minstr + 32'd1;
        if (ms == 0) begin
            if (start) begin
                ms = 1; pos = 0; wcnt = 0; new_instr = 1'b1;
            end
        end else if (ms == 15) begin
            ms = 15;
        end else if ((ms == 1 || ms == 4 || ms == 6) && !mem_ready) begin
            wcnt++;
            if (TMO > 0 && wcnt == TMO) ms = 15;
        end else begin
            wcnt = 0;
            pos++;
            nx = step_of(cur_op, pos);
            if (nx == 0) begin
                pos = 0; ms = 1; new_instr = 1'b1;
            end else begin
                ms = nx;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (new_instr) begin
            cur_op = next_op;
            op = next_op;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctrl", {14'b0, got_w}, {14'b0, exp_word(ms, mem_ready)});
            chk("state", {28'b0, state_o}, ms);
`ifdef MC_PERF_CNT_EN
            chk("cyc_cnt", cyc_cnt, mcyc);
            chk("instr_cnt", instr_cnt, minstr);
`endif
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; zero = 1'b0;
        mem_ready = 1'b0; op = '0;
        chk_en = 1'b1;
        do_reset();
        chk("reset_state", {28'b0, state_o}, 0);
        chk("reset_outs", {14'b0, got_w}, 0);

        // R-type, zero-wait memory: 1,2,7,8,1
        next_op = RT; start = 1'b1; mem_ready = 1'b1;
        tick(); chk("rt_s1", {28'b0, state_o}, 1);
        start = 1'b0;
        tick(); chk("rt_s2", {28'b0, state_o}, 2);
        tick(); chk("rt_s7", {28'b0, state_o}, 7);
        tick(); chk("rt_s8", {28'b0, state_o}, 8);
        chk("rt_wb", {30'b0, reg_write, reg_dst}, 3);
        next_op = LW;
        tick(); chk("rt_back", {28'b0, state_o}, 1);

        // lw with 3 wait cycles in MEMRD
        tick(); tick(); tick();
        chk("lw_memrd", {28'b0, state_o}, 4);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_hold", {26'b0, state_o, mem_req, iord}, 32'h13);
        end
        mem_ready = 1'b1;
        tick(); chk("lw_memwb", {28'b0, state_o}, 5);
        chk("lw_wb", {30'b0, reg_write, mem_to_reg}, 3);

        // beq with zero = 1
        next_op = BEQ; zero = 1'b1;
        tick(); tick(); tick();
        chk("beq_state", {28'b0, state_o}, 9);
        chk("beq_ctl", {29'b0, pc_write_cond, pc_src}, 5);
        next_op = 6'b111111;
        tick(); chk("beq_back", {28'b0, state_o}, 1);

        // unsupported opcode traps; start ignored; reset recovers
        tick(); tick();
        chk("trap_state", {28'b0, state_o}, 15);
        chk("trap_outs", {14'b0, got_w}, 1);
        start = 1'b1;
        tick(); tick();
        chk("trap_stay", {28'b0, state_o}, 15);
        do_reset();
        chk("trap_reset", {28'b0, state_o}, 0);

        // fetch timeout after TMO wait cycles
        next_op = RT; start = 1'b1; mem_ready = 1'b0;
        tick(); start = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            chk("tmo_wait", {28'b0, state_o}, 1);
        end
        tick(); chk("tmo_trap", {28'b0, state_o}, 15);

        // asynchronous reset in the middle of a stalled store
        do_reset();
        next_op = SW; start = 1'b1; mem_ready = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("sw_memwr", {28'b0, state_o}, 6);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {26'b0, state_o, mem_req, mem_write}, 0);
        model_reset();
        tick();
        rst_n = 1'b1;

`ifdef MC_PERF_CNT_EN
        do_reset();
        next_op = RT; start = 1'b1; mem_ready = 1'b1;
        tick(); start = 1'b0;
        repeat (12) tick();
        chk("perf_instr", instr_cnt, 3);
        chk("perf_cyc", cyc_cnt, 12);
`endif

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            mem_ready = ($urandom_range(0, 9) < 7);
            zero = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) begin
                next_op = 6'($urandom);
            end else begin
                next_op = ops[$urandom_range(0, 5)];
            end
            if (ms == 15 && $urandom_range(0, 5) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
